// File: rtl/best_tracker.sv
// Tracks the lowest-metric candidate of a search, counts candidates and queues
// threshold hits in a small FIFO, counting the hits lost when it is full.
module best_tracker #(
    parameter int MSG_W = 512,
    parameter int MW    = 9,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             cand_val_i,
    input  logic [MW-1:0]    metric_i,
    input  logic [MSG_W-1:0] msg_i,
    input  logic [MW-1:0]    thresh_i,
    input  logic             clear_i,
    output logic             hit_val_o,
    input  logic             hit_rdy_i,
    output logic [MW-1:0]    hit_metric_o,
    output logic [MSG_W-1:0] hit_msg_o,
    output logic [MW-1:0]    best_metric_o,
    output logic [MSG_W-1:0] best_msg_o,
    output logic             best_upd_o,
    output logic [47:0]      count_o,
    output logic [15:0]      drop_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [MW-1:0]    best_metric_q, best_metric_d;
    logic [MSG_W-1:0] best_msg_q, best_msg_d;
    logic             best_upd_q, best_upd_d;
    logic [47:0]      count_q, count_d;
    logic [15:0]      drop_q, drop_d;
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;

    logic [MW-1:0]    metric_mem [DEPTH];
    logic [MSG_W-1:0] msg_mem    [DEPTH];

    logic accept, hit, empty, full, pop, push;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign accept = cand_val_i && !clear_i;
    assign hit    = accept && (metric_i <= thresh_i);
    assign pop    = !empty && hit_rdy_i;
    assign push   = hit && (!full || pop);

    always_comb begin
        best_metric_d = best_metric_q;
        best_msg_d    = best_msg_q;
        best_upd_d    = 1'b0;
        count_d       = count_q;
        drop_d        = drop_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        if (clear_i) begin
            best_metric_d = {MW{1'b1}};
            best_msg_d    = '0;
            count_d       = '0;
            drop_d        = '0;
            wr_ptr_d      = '0;
            rd_ptr_d      = '0;
        end else begin
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (accept) begin
                count_d = count_q + 48'd1;
                // Strict compare keeps the earlier candidate on a tie.
                if (metric_i < best_metric_q) begin
                    best_metric_d = metric_i;
                    best_msg_d    = msg_i;
                    best_upd_d    = 1'b1;
                end
                if (hit && !push && (drop_q != 16'hFFFF)) begin
                    drop_d = drop_q + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            best_metric_q <= {MW{1'b1}};
            best_msg_q    <= '0;
            best_upd_q    <= 1'b0;
            count_q       <= '0;
            drop_q        <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
        end else begin
            best_metric_q <= best_metric_d;
            best_msg_q    <= best_msg_d;
            best_upd_q    <= best_upd_d;
            count_q       <= count_d;
            drop_q        <= drop_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
        end
    end

    // Storage is deliberately unreset; only the pointers define validity.
    always_ff @(posedge clk_i) begin
        if (push && !reset_i && !clear_i) begin
            metric_mem[wr_ptr_q[AW-1:0]] <= metric_i;
            msg_mem[wr_ptr_q[AW-1:0]]    <= msg_i;
        end
    end

    assign hit_val_o     = !empty;
    assign hit_metric_o  = metric_mem[rd_ptr_q[AW-1:0]];
    assign hit_msg_o     = msg_mem[rd_ptr_q[AW-1:0]];
    assign best_metric_o = best_metric_q;
    assign best_msg_o    = best_msg_q;
    assign best_upd_o    = best_upd_q;
    assign count_o       = count_q;
    assign drop_o        = drop_q;
endmodule

// File: tb/tb_best_tracker.sv
// Directed bench for best_tracker: a queue-based model checked every cycle,
// plus literal expectations for the key scenarios.
module tb_best_tracker;
    localparam int MSG_W = 512;
    localparam int MW    = 9;
    localparam int DEPTH = 4;

    logic             clk_i = 1'b0;
    logic             reset_i = 1'b0;
    logic             cand_val_i = 1'b0;
    logic [MW-1:0]    metric_i = '0;
    logic [MSG_W-1:0] msg_i = '0;
    logic [MW-1:0]    thresh_i = '0;
    logic             clear_i = 1'b0;
    logic             hit_rdy_i = 1'b0;
    logic             hit_val_o;
    logic [MW-1:0]    hit_metric_o;
    logic [MSG_W-1:0] hit_msg_o;
    logic [MW-1:0]    best_metric_o;
    logic [MSG_W-1:0] best_msg_o;
    logic             best_upd_o;
    logic [47:0]      count_o;
    logic [15:0]      drop_o;

    best_tracker #(.MSG_W(MSG_W), .MW(MW), .DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .cand_val_i(cand_val_i),
        .metric_i(metric_i), .msg_i(msg_i), .thresh_i(thresh_i),
        .clear_i(clear_i), .hit_val_o(hit_val_o), .hit_rdy_i(hit_rdy_i),
        .hit_metric_o(hit_metric_o), .hit_msg_o(hit_msg_o),
        .best_metric_o(best_metric_o), .best_msg_o(best_msg_o),
        .best_upd_o(best_upd_o), .count_o(count_o), .drop_o(drop_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int failures = 0;
    int upd_seen = 0;

    // Model: a queue of {metric,msg} hits plus plain best/count/drop values.
    typedef struct { logic [MW-1:0] metric; logic [MSG_W-1:0] msg; } hit_t;
    hit_t             m_q[$];
    logic [MW-1:0]    m_best;
    logic [MSG_W-1:0] m_msg;
    logic             m_upd;
    logic [47:0]      m_count;
    logic [15:0]      m_drop;

    function automatic logic [MSG_W-1:0] mk_msg(input int n);
        logic [31:0] w;
        w = 32'hA5A5_0000 ^ n;
        return {16{w}};
    endfunction

    task automatic check_val(input string name, input logic [MSG_W-1:0] act,
                             input logic [MSG_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_step();
        logic pop;
        m_upd = 1'b0;
        if (reset_i || clear_i) begin
            m_best = '1; m_msg = '0; m_count = '0; m_drop = '0;
            m_q.delete();
        end else begin
            pop = (m_q.size() != 0) && hit_rdy_i;
            if (pop) void'(m_q.pop_front());
            if (cand_val_i) begin
                m_count = m_count + 48'd1;
                if (metric_i < m_best) begin
                    m_best = metric_i; m_msg = msg_i; m_upd = 1'b1;
                end
                if (metric_i <= thresh_i) begin
                    // A pop this cycle has already freed a slot above.
                    if (m_q.size() < DEPTH) m_q.push_back('{metric_i, msg_i});
                    else if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
                end
            end
        end
    endtask

    task automatic checkOutput();
        upd_seen += int'(best_upd_o);
        check_val("hit_val", MSG_W'(hit_val_o), MSG_W'(m_q.size() != 0));
        if (m_q.size() != 0) begin
            check_val("hit_metric", MSG_W'(hit_metric_o), MSG_W'(m_q[0].metric));
            check_val("hit_msg", hit_msg_o, m_q[0].msg);
        end
        check_val("best_metric", MSG_W'(best_metric_o), MSG_W'(m_best));
        check_val("best_msg", best_msg_o, m_msg);
        check_val("best_upd", MSG_W'(best_upd_o), MSG_W'(m_upd));
        check_val("count", MSG_W'(count_o), MSG_W'(m_count));
        check_val("drop", MSG_W'(drop_o), MSG_W'(m_drop));
    endtask

    task automatic stepAndCheck();
        @(posedge clk_i);
        model_step();
        #1;
        checkOutput();
    endtask

    task automatic applyStimulus(input logic rst, input logic clr, input logic cv,
                                 input int metric, input int msg_id,
                                 input int thresh, input logic rdy);
        @(negedge clk_i);
        reset_i = rst; clear_i = clr; cand_val_i = cv;
        metric_i = MW'(metric); msg_i = mk_msg(msg_id);
        thresh_i = MW'(thresh); hit_rdy_i = rdy;
        stepAndCheck();
    endtask

    task automatic cand(input int metric, input int msg_id, input int thresh,
                        input logic rdy);
        applyStimulus(1'b0, 1'b0, 1'b1, metric, msg_id, thresh, rdy);
    endtask

    task automatic idle(input logic rdy);
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 0, rdy);
    endtask

    initial begin
        m_best = '1; m_msg = '0; m_upd = 1'b0; m_count = '0; m_drop = '0;

        // Reset state.
        applyStimulus(1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0);
        check_val("rst_best", MSG_W'(best_metric_o), MSG_W'(511));
        check_val("rst_count", MSG_W'(count_o), MSG_W'(0));
        check_val("rst_hit_val", MSG_W'(hit_val_o), MSG_W'(0));

        // Best tracking with tie: 80, 75, 75, 90 at thresh 0.
        upd_seen = 0;
        cand(80, 1, 0, 1'b0);
        cand(75, 2, 0, 1'b0);
        cand(75, 3, 0, 1'b0);
        cand(90, 4, 0, 1'b0);
        idle(1'b0);
        check_val("best75", MSG_W'(best_metric_o), MSG_W'(75));
        check_val("best75_msg", best_msg_o, mk_msg(2));
        check_val("upd_pulses", MSG_W'(upd_seen), MSG_W'(2));
        check_val("count4", MSG_W'(count_o), MSG_W'(4));
        check_val("no_hits", MSG_W'(hit_val_o), MSG_W'(0));

        // Six hits into a stalled FIFO: four kept in order, two dropped.
        applyStimulus(1'b0, 1'b1, 1'b0, 0, 0, 0, 1'b0);
        for (int i = 1; i <= 6; i++) cand(i, 10 + i, 10, 1'b0);
        check_val("drop2", MSG_W'(drop_o), MSG_W'(2));
        check_val("head1_val", MSG_W'(hit_val_o), MSG_W'(1));
        check_val("head1_metric", MSG_W'(hit_metric_o), MSG_W'(1));
        check_val("head1_msg", hit_msg_o, mk_msg(11));

        // Full FIFO with a pop in the same cycle accepts the new hit.
        cand(7, 17, 10, 1'b1);
        check_val("full_push_drop", MSG_W'(drop_o), MSG_W'(2));
        check_val("full_push_size", MSG_W'(m_q.size()), MSG_W'(4));
        check_val("head2_metric", MSG_W'(hit_metric_o), MSG_W'(2));
        idle(1'b0);
        for (int i = 0; i < 5; i++) idle(1'b1);
        check_val("drained", MSG_W'(hit_val_o), MSG_W'(0));

        // Reset mid-drain with three entries queued.
        applyStimulus(1'b0, 1'b1, 1'b0, 0, 0, 0, 1'b0);
        for (int i = 0; i < 4; i++) cand(5 + i, 30 + i, 10, 1'b0);
        idle(1'b1);
        check_val("three_left_metric", MSG_W'(hit_metric_o), MSG_W'(6));
        applyStimulus(1'b1, 1'b1, 1'b1, 2, 40, 10, 1'b0);
        check_val("rst_mid_val", MSG_W'(hit_val_o), MSG_W'(0));
        check_val("rst_mid_count", MSG_W'(count_o), MSG_W'(0));
        cand(4, 41, 10, 1'b0);
        check_val("post_rst_val", MSG_W'(hit_val_o), MSG_W'(1));
        check_val("post_rst_metric", MSG_W'(hit_metric_o), MSG_W'(4));

        // Clear together with a candidate discards it.
        cand(50, 42, 0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1, 3, 43, 10, 1'b0);
        check_val("clr_best", MSG_W'(best_metric_o), MSG_W'(511));
        check_val("clr_count", MSG_W'(count_o), MSG_W'(0));
        check_val("clr_hit_val", MSG_W'(hit_val_o), MSG_W'(0));
        check_val("clr_upd", MSG_W'(best_upd_o), MSG_W'(0));

        // Counter wrap from a forced all-ones value.
        @(negedge clk_i);
        cand_val_i = 1'b0; clear_i = 1'b0; reset_i = 1'b0; hit_rdy_i = 1'b0;
        force dut.count_q = 48'hFFFF_FFFF_FFFF;
        #1 release dut.count_q;
        m_count = 48'hFFFF_FFFF_FFFF;
        stepAndCheck();
        cand(20, 50, 0, 1'b0);
        check_val("count_wrap", MSG_W'(count_o), MSG_W'(0));

        // Drop counter saturates at 0xFFFF.
        for (int i = 0; i < 4; i++) cand(1 + i, 60 + i, 10, 1'b0);
        @(negedge clk_i);
        cand_val_i = 1'b0;
        force dut.drop_q = 16'hFFFF;
        #1 release dut.drop_q;
        m_drop = 16'hFFFF;
        stepAndCheck();
        cand(9, 70, 10, 1'b0);
        check_val("drop_sat", MSG_W'(drop_o), MSG_W'(16'hFFFF));
        idle(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/best_tracker.md
BEST_TRACKER -- requirements
Module: best_tracker

Interface
REQ-001 SHALL have parameter MSG_W, default 512, giving the candidate message width in bits (512 per SHA-1 block).
REQ-002 SHALL have parameter MW, default 9, giving the metric width (range 0..160 plus spare).
REQ-003 SHALL have parameter DEPTH, default 4, giving the hit FIFO entry count; it must be a power of two and at least 2.
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset_i, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port cand_val_i, input, 1 bit: the candidate on metric_i/msg_i is valid this cycle.
REQ-007 SHALL have port metric_i, input, MW bits: the candidate's distance to the target digest; lower is better.
REQ-008 SHALL have port msg_i, input, MSG_W bits: the candidate message.
REQ-009 SHALL have port thresh_i, input, MW bits: the hit threshold; a candidate is a hit when metric_i <= thresh_i.
REQ-010 SHALL have port clear_i, input, 1 bit: software restart of a search.
REQ-011 SHALL have port hit_val_o, output, 1 bit: the FIFO head is valid.
REQ-012 SHALL have port hit_rdy_i, input, 1 bit: the consumer accepts the FIFO head.
REQ-013 SHALL have port hit_metric_o, output, MW bits: the metric of the FIFO head.
REQ-014 SHALL have port hit_msg_o, output, MSG_W bits: the message of the FIFO head.
REQ-015 SHALL have port best_metric_o, output, MW bits: the lowest metric seen since reset or clear.
REQ-016 SHALL have port best_msg_o, output, MSG_W bits: the message that produced best_metric_o.
REQ-017 SHALL have port best_upd_o, output, 1 bit: a one-cycle pulse marking a best update.
REQ-018 SHALL have port count_o, output, 48 bits: the number of candidates evaluated.
REQ-019 SHALL have port drop_o, output, 16 bits: the number of hits lost because the FIFO was full.

Function
REQ-020 SHALL sample candidates only when cand_val_i=1; all other cycles leave state unchanged except for FIFO pops.
REQ-021 SHALL, on an accepted candidate, increment count_o one cycle later; count_o wraps modulo 2^48.
REQ-022 SHALL replace the best entry only when metric_i < best_metric_o (strict); on a tie the earlier candidate is kept.
REQ-023 SHALL update best_metric_o and best_msg_o one cycle after a replacing candidate, with best_upd_o=1 in that same cycle and 0 otherwise.
REQ-024 SHALL push {metric_i, msg_i} into the FIFO when a candidate is a hit and a slot is available.
REQ-025 SHALL treat a slot as available when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
REQ-026 SHALL, for a hit with no available slot, discard the hit and increment drop_o, saturating at 0xFFFF; the best tracking and count are still updated.
REQ-027 SHALL pop the FIFO when hit_val_o=1 and hit_rdy_i=1.
REQ-028 SHALL hold the head data stable while hit_val_o=1 and hit_rdy_i=0.
REQ-029 SHALL preserve FIFO order as push order.
REQ-030 SHALL raise hit_val_o the cycle after a push into an empty FIFO; there is no combinational input-to-output path.
REQ-031 SHALL, on a simultaneous push and pop with the FIFO empty, be unreachable by construction, since a pop requires hit_val_o=1.
REQ-032 SHALL, when clear_i=1, on the next cycle set best_metric_o to all ones and best_msg_o, count_o and drop_o to 0, and flush the FIFO (hit_val_o=0).
REQ-033 SHALL discard and not count any candidate presented in the clear_i cycle.
REQ-034 SHALL evaluate thresh_i in the same cycle as the candidate; changing it never re-qualifies entries already in the FIFO.

Reset
REQ-035 SHALL, while reset_i=1 at a clock edge, set hit_val_o=0, best_upd_o=0, best_metric_o=all ones (511 at MW=9), and best_msg_o, count_o and drop_o to 0, with FIFO pointers at empty.
REQ-036 SHALL give reset priority over clear_i and cand_val_i, including reset asserted in the middle of a back-pressured drain.
REQ-037 SHALL leave FIFO storage contents unreset; only valid/pointer state is reset.

Verification
REQ-038 SHALL be covered by a bench scenario where, after reset, candidates with metrics 80, 75, 75, 90 at thresh_i=0 give best_metric_o=75 with the first 75's message, best_upd_o pulsing twice, count_o=4, and hit_val_o=0.
REQ-039 SHALL be covered by a bench scenario where, with thresh_i=10 and DEPTH=4 and hit_rdy_i=0, six hits give four entries held in order, drop_o=2, and hit_val_o=1 with the first hit's metric and message.
REQ-040 SHALL be covered by a bench scenario where, with the FIFO full and hit_rdy_i=1, a hit in the same cycle is pushed and not dropped, drop_o is unchanged, and the FIFO stays full.
REQ-041 SHALL be covered by a bench scenario where clear_i is asserted together with cand_val_i (metric 3) so that the next cycle shows best_metric_o=511, count_o=0, hit_val_o=0, and no best_upd_o pulse.
REQ-042 SHALL be covered by a bench scenario where reset_i is asserted for one cycle mid-drain with three entries queued, giving hit_val_o=0 and count_o=0 the following cycle, with later pushes taking effect normally.
REQ-043 SHALL be covered by a bench scenario where, with count_o preloaded (via force) to 2^48-1, one candidate makes count_o=0, and with drop_o at 0xFFFF a further drop holds it at 0xFFFF.
